// File: rtl/posit_pkg.sv
// Shared posit constants and serializer state encoding, also used by the multiplier side.
package posit_pkg;

    localparam int MAX_PREC = 8;
    localparam int CNT_W    = 4;
    localparam int IDX_W    = $clog2(MAX_PREC);

    localparam logic [CNT_W-1:0] PREC_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] PREC_MAX   = CNT_W'(MAX_PREC);
    localparam logic [CNT_W-1:0] PREC_RESET = CNT_W'(MAX_PREC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } ser_state_t;

    function automatic logic prec_legal(input logic [CNT_W-1:0] p);
        return (p >= PREC_MIN) && (p <= PREC_MAX);
    endfunction

endpackage

// File: rtl/posit_weight_serializer_if.sv
// Weight handshake, configuration and serial stream bundle for posit_weight_serializer.
interface posit_weight_serializer_if;
    import posit_pkg::*;

    logic                cfg_set;
    logic [CNT_W-1:0]    cfg_precision;
    logic                cfg_err;
    logic [CNT_W-1:0]    prec_out;
    logic                set_out;
    logic [MAX_PREC-1:0] weight_in;
    logic                weight_valid;
    logic                weight_ready;
    logic                stall;
    logic                w;
    logic                w_valid;
    logic                frame_first;
    logic                frame_last;
    logic                busy;

    modport slave (
        input  cfg_set, cfg_precision, weight_in, weight_valid, stall,
        output cfg_err, prec_out, set_out, weight_ready,
               w, w_valid, frame_first, frame_last, busy
    );

    modport master (
        output cfg_set, cfg_precision, weight_in, weight_valid, stall,
        input  cfg_err, prec_out, set_out, weight_ready,
               w, w_valid, frame_first, frame_last, busy
    );

endinterface

// File: rtl/posit_shift_reg.sv
// Parallel-load posit shifter: indexed MSB-first bit select with a down-counter and frame flags.
module posit_shift_reg
    import posit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [MAX_PREC-1:0] load_data,
    input  logic [CNT_W-1:0]    load_prec,
    output logic                bit_out,
    output logic                is_first,
    output logic                is_last,
    output logic                is_penult
);

    logic [MAX_PREC-1:0] data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                first_q;

    // A load wins over a shift so the next frame can start on the edge that emits bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            cnt_q   <= load_prec - CNT_W'(1);
            first_q <= 1'b1;
        end else if (shift) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            first_q <= 1'b0;
        end
    end

    assign bit_out   = data_q[cnt_q[IDX_W-1:0]];
    assign is_first  = first_q;
    assign is_last   = (cnt_q == '0);
    assign is_penult = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/posit_weight_serializer.sv
// Serializes parallel es=0 posit weights MSB-first for the FP x posit multiplier.
module posit_weight_serializer
    import posit_pkg::*;
(
    input logic                       clk,
    input logic                       rst,
    posit_weight_serializer_if.slave  sif
);

    ser_state_t          state;
    logic                hold_full;
    logic [MAX_PREC-1:0] hold_data;
    logic [CNT_W-1:0]    prec_q;
    logic                w_q, w_valid_q, first_q, last_q, cfg_err_q, set_q;

    logic accept, busy, shift, load, cfg_ok;
    logic sh_bit, sh_first, sh_last, sh_penult;

    assign busy   = (state != ST_IDLE) || hold_full;
    assign accept = sif.weight_valid && !hold_full;
    assign shift  = !sif.stall && (state != ST_IDLE);
    assign load   = !sif.stall && hold_full && ((state == ST_IDLE) || sh_last);
    assign cfg_ok = sif.cfg_set && !busy && prec_legal(sif.cfg_precision);

    posit_shift_reg u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (hold_data),
        .load_prec (prec_q),
        .bit_out   (sh_bit),
        .is_first  (sh_first),
        .is_last   (sh_last),
        .is_penult (sh_penult)
    );

    // Accept and load can never coincide: one needs hold empty, the other hold full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= sif.weight_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            prec_q    <= PREC_RESET;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            set_q     <= 1'b0;
        end else begin
            cfg_err_q <= sif.cfg_set && !cfg_ok;
            set_q     <= cfg_ok;
            if (cfg_ok) begin
                prec_q <= sif.cfg_precision;
            end

            w_valid_q <= shift;
            first_q   <= shift && sh_first;
            last_q    <= shift && sh_last;
            if (shift) begin
                w_q <= sh_bit;
            end

            // DRAIN marks a last bit with nothing queued behind it.
            case (state)
                ST_IDLE: begin
                    if (load) state <= ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    if (shift) begin
                        if (sh_last)
                            state <= load ? ST_RUN : ST_IDLE;
                        else if (sh_penult && !hold_full)
                            state <= ST_DRAIN;
                        else
                            state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sif.weight_ready = !hold_full;
    assign sif.busy         = busy;
    assign sif.prec_out     = prec_q;
    assign sif.set_out      = set_q;
    assign sif.cfg_err      = cfg_err_q;
    assign sif.w            = w_q;
    assign sif.w_valid      = w_valid_q;
    assign sif.frame_first  = first_q;
    assign sif.frame_last   = last_q;

endmodule

// File: tb/tb_posit_weight_serializer.sv
// Directed self-checking bench for posit_weight_serializer with a serial-stream recorder.
module tb_posit_weight_serializer;
    import posit_pkg::*;

    logic clk;
    logic rst;
    int   vec_count;
    int   miss_count;
    int   cyc;
    logic [2:0] rec_q[$];
    int         rec_cyc[$];

    posit_weight_serializer_if sif();

    posit_weight_serializer dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every valid serial bit with its flags and the cycle it appeared in.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sif.w_valid === 1'b1) begin
            rec_q.push_back({sif.frame_first, sif.frame_last, sif.w});
            rec_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Present a weight and hold valid until the handshake edge; returns 2ns after that edge.
    task automatic applyStimulus(input logic [MAX_PREC-1:0] value);
        bit done;
        done = 1'b0;
        sif.weight_in    = value;
        sif.weight_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (sif.weight_ready === 1'b1) done = 1'b1;
            nextCycle();
        end
        sif.weight_valid = 1'b0;
        if (!done) checkOutput("handshake_timeout", 32'd1, 32'd0);
    endtask

    task automatic doConfig(input logic [CNT_W-1:0] p);
        sif.cfg_set       = 1'b1;
        sif.cfg_precision = p;
        nextCycle();
        sif.cfg_set = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            nextCycle();
            if (sif.busy === 1'b0 && sif.w_valid === 1'b0) idle = 1'b1;
        end
        if (!idle) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic clearRec();
        rec_q.delete();
        rec_cyc.delete();
    endtask

    // Compare recorded frame bits, first/last flags and cycle span against expectations.
    task automatic checkFrame(input string tag, input logic [15:0] bits, input int n,
                              input int p, input int span);
        logic [15:0] obs_bits, obs_first, obs_last, exp_first, exp_last, exp_bits;
        checkOutput({tag, "_len"}, rec_q.size(), n);
        if (rec_q.size() == n) begin
            obs_bits = '0; obs_first = '0; obs_last = '0;
            exp_first = '0; exp_last = '0;
            exp_bits = bits & ((16'd1 << n) - 16'd1);
            for (int i = 0; i < n; i++) begin
                obs_bits[n-1-i]  = rec_q[i][0];
                obs_last[n-1-i]  = rec_q[i][1];
                obs_first[n-1-i] = rec_q[i][2];
                if (i % p == 0)     exp_first[n-1-i] = 1'b1;
                if (i % p == p - 1) exp_last[n-1-i]  = 1'b1;
            end
            checkOutput({tag, "_bits"}, obs_bits, exp_bits);
            checkOutput({tag, "_first"}, obs_first, exp_first);
            checkOutput({tag, "_last"}, obs_last, exp_last);
            checkOutput({tag, "_span"}, rec_cyc[n-1] - rec_cyc[0], span);
        end
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        cyc        = 0;
        rst        = 1'b1;
        sif.cfg_set       = 1'b0;
        sif.cfg_precision = '0;
        sif.weight_in     = '0;
        sif.weight_valid  = 1'b0;
        sif.stall         = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_w_valid", sif.w_valid, 1'b0);
        checkOutput("rst_ready", sif.weight_ready, 1'b1);
        checkOutput("rst_busy", sif.busy, 1'b0);
        checkOutput("rst_prec", sif.prec_out, 4'd8);
        checkOutput("rst_set_err", {sif.set_out, sif.cfg_err, sif.frame_first, sif.frame_last}, 4'b0);

        $display("[TB] P=4 single frame");
        doConfig(4'd4);
        checkOutput("t1_set_pulse", sif.set_out, 1'b1);
        checkOutput("t1_prec", sif.prec_out, 4'd4);
        nextCycle();
        checkOutput("t1_set_drop", sif.set_out, 1'b0);
        clearRec();
        applyStimulus(8'hA6);
        checkOutput("t1_lat0", sif.w_valid, 1'b0);
        nextCycle();
        checkOutput("t1_lat1", sif.w_valid, 1'b0);
        nextCycle();
        checkOutput("t1_lat2", {sif.w_valid, sif.frame_first, sif.w}, 3'b110);
        waitIdle();
        checkFrame("t1", 16'b0110, 4, 4, 3);

        $display("[TB] P=8 back-to-back");
        doConfig(4'd8);
        clearRec();
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        checkOutput("t2_ready_full", sif.weight_ready, 1'b0);
        waitIdle();
        checkFrame("t2", 16'h5AC3, 16, 8, 15);

        $display("[TB] P=6 stall");
        doConfig(4'd6);
        clearRec();
        applyStimulus(8'h35);
        repeat (3) nextCycle();
        sif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("t3_stall%0d", i), {sif.w_valid, sif.w}, 2'b01);
        end
        sif.stall = 1'b0;
        waitIdle();
        checkFrame("t3", 16'b110101, 6, 6, 8);

        $display("[TB] rejected config");
        clearRec();
        applyStimulus(8'hDC);
        sif.cfg_set       = 1'b1;
        sif.cfg_precision = 4'd5;
        nextCycle();
        sif.cfg_set = 1'b0;
        checkOutput("t4_busy_err", {sif.cfg_err, sif.set_out}, 2'b10);
        checkOutput("t4_busy_prec", sif.prec_out, 4'd6);
        waitIdle();
        checkFrame("t4", 16'b011100, 6, 6, 5);
        doConfig(4'd9);
        checkOutput("t4_big_err", {sif.cfg_err, sif.set_out}, 2'b10);
        checkOutput("t4_big_prec", sif.prec_out, 4'd6);
        doConfig(4'd1);
        checkOutput("t4_small_err", {sif.cfg_err, sif.prec_out}, {1'b1, 4'd6});

        $display("[TB] P=2 config with weight in same cycle");
        clearRec();
        sif.cfg_set       = 1'b1;
        sif.cfg_precision = 4'd2;
        applyStimulus(8'hFE);
        sif.cfg_set = 1'b0;
        checkOutput("t4b_set", {sif.set_out, sif.cfg_err, sif.prec_out}, {2'b10, 4'd2});
        waitIdle();
        checkFrame("t4b", 16'b10, 2, 2, 1);

        $display("[TB] reset mid-frame");
        doConfig(4'd8);
        clearRec();
        applyStimulus(8'hB7);
        repeat (4) nextCycle();
        checkOutput("t5_third_bit", {sif.w_valid, sif.w}, 2'b11);
        #1 rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", sif.w_valid, 1'b0);
        checkOutput("t5_rst_ready", {sif.weight_ready, sif.busy}, 2'b10);
        checkOutput("t5_rst_prec", sif.prec_out, 4'd8);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
        clearRec();
        applyStimulus(8'h96);
        waitIdle();
        checkFrame("t5", 16'h0096, 8, 8, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
